// File: rtl/bg_affine_overflow_unit.sv
// Affine BG2/BG3 texture coordinate generator with per-channel wrap/transparent.
// Optional per-channel horizontal mosaic under `BG_AFFINE_MOSAIC_EN.
module bg_affine_overflow_unit #(
  parameter int CHANNELS = 2,
  parameter int COORD_W  = 28,
  parameter int PARAM_W  = 16,
  parameter int SIZE_W   = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        line_start,
  input  logic                        pixel_step,
  input  logic [CHANNELS*COORD_W-1:0] ref_x,
  input  logic [CHANNELS*COORD_W-1:0] ref_y,
  input  logic [CHANNELS*PARAM_W-1:0] pa,
  input  logic [CHANNELS*PARAM_W-1:0] pb,
  input  logic [CHANNELS*PARAM_W-1:0] pc,
  input  logic [CHANNELS*PARAM_W-1:0] pd,
  input  logic [CHANNELS*SIZE_W-1:0]  hmax,
  input  logic [CHANNELS*SIZE_W-1:0]  vmax,
  input  logic [CHANNELS-1:0]         bitmapped,
  input  logic [CHANNELS-1:0]         wrap,
`ifdef BG_AFFINE_MOSAIC_EN
  input  logic [CHANNELS-1:0]         mosaic_en,
  input  logic [3:0]                  mosaic_h,
`endif
  output logic [CHANNELS*SIZE_W-1:0]  tex_x,
  output logic [CHANNELS*SIZE_W-1:0]  tex_y,
  output logic [CHANNELS-1:0]         transparent,
  output logic                        out_valid
);

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic [SIZE_W-1:0]         hmax;
    logic [SIZE_W-1:0]         vmax;
    logic                      bm;
    logic                      wrap;
  } s1_t;

  function automatic coord_t sext(
    input logic [PARAM_W-1:0] p
  );
    return {{(COORD_W-PARAM_W){p[PARAM_W-1]}}, p};
  endfunction

  coord_t lx_q [CHANNELS];
  coord_t lx_d [CHANNELS];
  coord_t ly_q [CHANNELS];
  coord_t ly_d [CHANNELS];
  coord_t cx_q [CHANNELS];
  coord_t cx_d [CHANNELS];
  coord_t cy_q [CHANNELS];
  coord_t cy_d [CHANNELS];

  s1_t  s1_q [CHANNELS];
  s1_t  s1_d [CHANNELS];
  logic s1_vld_q;
  logic s1_vld_d;

  logic [CHANNELS*SIZE_W-1:0] tex_x_q;
  logic [CHANNELS*SIZE_W-1:0] tex_x_d;
  logic [CHANNELS*SIZE_W-1:0] tex_y_q;
  logic [CHANNELS*SIZE_W-1:0] tex_y_d;
  logic [CHANNELS-1:0]        transp_q;
  logic [CHANNELS-1:0]        transp_d;
  logic                       out_valid_q;
  logic                       out_valid_d;

  logic step_ok;

`ifdef BG_AFFINE_MOSAIC_EN
  logic [3:0] cnt_q [CHANNELS];
  logic [3:0] cnt_d [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (line_start) begin
        cnt_d[c] = 4'd0;
      end else if (step_ok) begin
        if (cnt_q[c] == mosaic_h) begin
          cnt_d[c] = 4'd0;
        end else begin
          cnt_d[c] = cnt_q[c] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset) begin
        cnt_q[c] <= 4'd0;
      end else begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end
`endif

  // accumulators and stage-1 capture
  always_comb begin
    step_ok  = pixel_step & ~frame_start & ~line_start;
    s1_vld_d = step_ok;
    for (int c = 0; c < CHANNELS; c++) begin : acc
      coord_t bx;
      coord_t by;
      logic   hold;
      lx_d[c] = lx_q[c];
      ly_d[c] = ly_q[c];
      cx_d[c] = cx_q[c];
      cy_d[c] = cy_q[c];
      s1_d[c] = s1_q[c];
      bx = lx_q[c];
      by = ly_q[c];
`ifdef BG_AFFINE_MOSAIC_EN
      hold = mosaic_en[c] && (cnt_q[c] != 4'd0);
`else
      hold = 1'b0;
`endif
      if (frame_start) begin
        bx = ref_x[c*COORD_W +: COORD_W];
        by = ref_y[c*COORD_W +: COORD_W];
        lx_d[c] = bx;
        ly_d[c] = by;
      end
      if (line_start) begin
        cx_d[c] = bx;
        cy_d[c] = by;
        lx_d[c] = bx + sext(pb[c*PARAM_W +: PARAM_W]);
        ly_d[c] = by + sext(pd[c*PARAM_W +: PARAM_W]);
      end else if (step_ok) begin
        cx_d[c] = cx_q[c] + sext(pa[c*PARAM_W +: PARAM_W]);
        cy_d[c] = cy_q[c] + sext(pc[c*PARAM_W +: PARAM_W]);
      end
      if (step_ok) begin
        // mosaic repeats the previously captured coordinate
        if (!hold) begin
          s1_d[c].x = cx_q[c];
          s1_d[c].y = cy_q[c];
        end
        s1_d[c].hmax = hmax[c*SIZE_W +: SIZE_W];
        s1_d[c].vmax = vmax[c*SIZE_W +: SIZE_W];
        s1_d[c].bm   = bitmapped[c];
        s1_d[c].wrap = wrap[c];
      end
    end
  end

  // stage 2: integer part, range check, wrap or transparent
  always_comb begin
    tex_x_d     = tex_x_q;
    tex_y_d     = tex_y_q;
    transp_d    = transp_q;
    out_valid_d = s1_vld_q;
    for (int c = 0; c < CHANNELS; c++) begin : ovf_chk
      coord_t            ix;
      coord_t            iy;
      coord_t            hm;
      coord_t            vm;
      logic              ovf;
      logic [SIZE_W-1:0] mx;
      logic [SIZE_W-1:0] my;
      logic [SIZE_W-1:0] tx;
      logic [SIZE_W-1:0] ty;
      logic              tr;
      ix  = $signed(s1_q[c].x) >>> 8;
      iy  = $signed(s1_q[c].y) >>> 8;
      hm  = {{(COORD_W-SIZE_W){1'b0}}, s1_q[c].hmax};
      vm  = {{(COORD_W-SIZE_W){1'b0}}, s1_q[c].vmax};
      ovf = (ix < 0) | (ix > hm) | (iy < 0) | (iy > vm);
      mx  = ix[SIZE_W-1:0] & s1_q[c].hmax;
      my  = iy[SIZE_W-1:0] & s1_q[c].vmax;
      tx  = mx;
      ty  = my;
      tr  = 1'b1;
      unique case (1'b1)
        !ovf: begin
          tx = ix[SIZE_W-1:0];
          ty = iy[SIZE_W-1:0];
          tr = 1'b0;
        end
        ovf & s1_q[c].bm: begin
          tr = 1'b1;
        end
        ovf & ~s1_q[c].bm & s1_q[c].wrap: begin
          tr = 1'b0;
        end
        ovf & ~s1_q[c].bm & ~s1_q[c].wrap: begin
          tr = 1'b1;
        end
        default: begin
          tr = 1'b1;
        end
      endcase
      if (s1_vld_q) begin
        tex_x_d[c*SIZE_W +: SIZE_W] = tx;
        tex_y_d[c*SIZE_W +: SIZE_W] = ty;
        transp_d[c]                 = tr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q    <= 1'b0;
      tex_x_q     <= '0;
      tex_y_q     <= '0;
      transp_q    <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        lx_q[c] <= '0;
        ly_q[c] <= '0;
        cx_q[c] <= '0;
        cy_q[c] <= '0;
        s1_q[c] <= '0;
      end
    end else begin
      s1_vld_q    <= s1_vld_d;
      tex_x_q     <= tex_x_d;
      tex_y_q     <= tex_y_d;
      transp_q    <= transp_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < CHANNELS; c++) begin
        lx_q[c] <= lx_d[c];
        ly_q[c] <= ly_d[c];
        cx_q[c] <= cx_d[c];
        cy_q[c] <= cy_d[c];
        s1_q[c] <= s1_d[c];
      end
    end
  end

  assign tex_x       = tex_x_q;
  assign tex_y       = tex_y_q;
  assign transparent = transp_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_bg_affine_overflow_unit.sv
// Directed bench for bg_affine_overflow_unit with an expected-result queue.
// Define BG_AFFINE_MOSAIC_EN to also exercise the mosaic path.
module tb_bg_affine_overflow_unit;

  localparam int CH = 2;
  localparam int CW = 28;
  localparam int PW = 16;
  localparam int SW = 10;

  logic clock = 1'b0;
  logic reset;
  logic frame_start;
  logic line_start;
  logic pixel_step;
  logic [CH*CW-1:0] ref_x;
  logic [CH*CW-1:0] ref_y;
  logic [CH*PW-1:0] pa;
  logic [CH*PW-1:0] pb;
  logic [CH*PW-1:0] pc;
  logic [CH*PW-1:0] pd;
  logic [CH*SW-1:0] hmax;
  logic [CH*SW-1:0] vmax;
  logic [CH-1:0]    bitmapped;
  logic [CH-1:0]    wrap;
`ifdef BG_AFFINE_MOSAIC_EN
  logic [CH-1:0]    mosaic_en;
  logic [3:0]       mosaic_h;
`endif
  logic [CH*SW-1:0] tex_x;
  logic [CH*SW-1:0] tex_y;
  logic [CH-1:0]    transparent;
  logic             out_valid;

  bg_affine_overflow_unit #(
    .CHANNELS(CH), .COORD_W(CW), .PARAM_W(PW), .SIZE_W(SW)
  ) dut (
    .clock(clock), .reset(reset),
    .frame_start(frame_start), .line_start(line_start),
    .pixel_step(pixel_step),
    .ref_x(ref_x), .ref_y(ref_y),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd),
    .hmax(hmax), .vmax(vmax),
    .bitmapped(bitmapped), .wrap(wrap),
`ifdef BG_AFFINE_MOSAIC_EN
    .mosaic_en(mosaic_en), .mosaic_h(mosaic_h),
`endif
    .tex_x(tex_x), .tex_y(tex_y),
    .transparent(transparent), .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic        t0;
    logic        k0;
    logic [9:0]  x1;
    logic [9:0]  y1;
    logic        t1;
    logic        k1;
    logic [31:0] due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [9:0] hx0, hy0, hx1, hy1;
  logic       ht0, ht1, hk0, hk1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(
    input int x0, input int y0, input logic t0, input logic k0,
    input int x1, input int y1, input logic t1, input logic k1
  );
    exp_t e;
    e.x0 = x0[9:0]; e.y0 = y0[9:0]; e.t0 = t0; e.k0 = k0;
    e.x1 = x1[9:0]; e.y1 = y1[9:0]; e.t1 = t1; e.k1 = k1;
    e.due = 0;
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      hx0 = 0; hy0 = 0; hx1 = 0; hy1 = 0;
      ht0 = 0; ht1 = 0; hk0 = 1; hk1 = 1;
    end else begin
      if (sb.size() != 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $error("FAIL missed_result: got none expected due cyc %0d", e.due);
      end
      if (sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("out_valid", out_valid, 1);
        chk("transp0", transparent[0], e.t0);
        chk("transp1", transparent[1], e.t1);
        if (e.k0) begin
          chk("tex_x0", tex_x[0 +: SW], e.x0);
          chk("tex_y0", tex_y[0 +: SW], e.y0);
        end
        if (e.k1) begin
          chk("tex_x1", tex_x[SW +: SW], e.x1);
          chk("tex_y1", tex_y[SW +: SW], e.y1);
        end
        hx0 = e.x0; hy0 = e.y0; hk0 = e.k0; ht0 = e.t0;
        hx1 = e.x1; hy1 = e.y1; hk1 = e.k1; ht1 = e.t1;
      end else begin
        chk("idle_valid", out_valid, 0);
        chk("hold_transp", transparent, {ht1, ht0});
        if (hk0) chk("hold_x0", tex_x[0 +: SW], hx0);
        if (hk1) chk("hold_y1", tex_y[SW +: SW], hy1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic fs, input logic ls, input logic ps);
    frame_start = fs;
    line_start  = ls;
    pixel_step  = ps;
    tick();
    frame_start = 0;
    line_start  = 0;
    pixel_step  = 0;
  endtask

  task automatic step(input exp_t e);
    e.due = cyc + 2;
    sb.push_back(e);
    strobe(0, 0, 1);
  endtask

  task automatic cfg(
    input int c, input logic [27:0] rx, input logic [27:0] ry,
    input logic [15:0] a, input logic [15:0] b,
    input logic [15:0] cc, input logic [15:0] d,
    input logic [9:0] hm, input logic [9:0] vm,
    input logic bm, input logic wr
  );
    ref_x[c*CW +: CW] = rx;
    ref_y[c*CW +: CW] = ry;
    pa[c*PW +: PW]    = a;
    pb[c*PW +: PW]    = b;
    pc[c*PW +: PW]    = cc;
    pd[c*PW +: PW]    = d;
    hmax[c*SW +: SW]  = hm;
    vmax[c*SW +: SW]  = vm;
    bitmapped[c]      = bm;
    wrap[c]           = wr;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  initial begin
    reset = 1; frame_start = 0; line_start = 0; pixel_step = 0;
    ref_x = '0; ref_y = '0; pa = '0; pb = '0; pc = '0; pd = '0;
    hmax = '0; vmax = '0; bitmapped = '0; wrap = '0;
`ifdef BG_AFFINE_MOSAIC_EN
    mosaic_en = '0; mosaic_h = '0;
`endif
    repeat (3) tick();
    chk("rst_tex_x", tex_x, 0);
    chk("rst_tex_y", tex_y, 0);
    chk("rst_transp", transparent, 0);
    chk("rst_valid", out_valid, 0);
    reset = 0;
    tick();

    // identity; channel 1 offset to (10,5)
    cfg(0, 0, 0, 16'h100, 0, 0, 16'h100, 255, 255, 0, 0);
    cfg(1, 28'd10 << 8, 28'd5 << 8, 16'h100, 0, 0, 16'h100,
        255, 255, 0, 0);
    strobe(1, 0, 0);
    strobe(0, 1, 0);
    for (int k = 0; k < 4; k++) step(mk(k, 0, 0, 1, 10 + k, 5, 0, 1));
    drain();

    // wrap at the right edge; channel 1 wraps a 4-wide map
    cfg(0, 28'd254 << 8, 0, 16'h100, 0, 0, 16'h100, 255, 255, 0, 1);
    cfg(1, 0, 0, 16'h200, 0, 0, 16'h100, 3, 3, 0, 1);
    strobe(1, 1, 0);
    step(mk(254, 0, 0, 1, 0, 0, 0, 1));
    step(mk(255, 0, 0, 1, 2, 0, 0, 1));
    step(mk(0, 0, 0, 1, 0, 0, 0, 1));
    step(mk(1, 0, 0, 1, 2, 0, 0, 1));
    drain();

    // no wrap / bitmapped: transparent past the edge
    cfg(0, 28'd254 << 8, 0, 16'h100, 0, 0, 16'h100, 255, 255, 0, 0);
    cfg(1, 28'd254 << 8, 0, 16'h100, 0, 0, 16'h100, 255, 255, 1, 1);
    strobe(1, 1, 0);
    for (int k = 0; k < 4; k++)
      step(mk(254 + k, 0, k >= 2, k < 2, 254 + k, 0, k >= 2, k < 2));
    drain();

    // negative coordinate, then exactly zero
    cfg(0, 28'hFFFFF00, 0, 16'h100, 0, 0, 16'h100, 127, 255, 0, 1);
    cfg(1, 28'hFFFFF00, 0, 16'h100, 0, 0, 16'h100, 127, 255, 0, 0);
    strobe(1, 1, 0);
    step(mk(127, 0, 0, 1, 0, 0, 1, 0));
    step(mk(0, 0, 0, 1, 0, 0, 0, 1));
    drain();

    // line stepping; a step alongside line_start is dropped
    cfg(0, 0, 0, 16'h100, 16'h80, 0, 16'h100, 255, 255, 0, 0);
    cfg(1, 28'd5 << 8, 0, 16'h100, 16'hFF00, 0, 16'h100,
        255, 255, 0, 0);
    strobe(1, 0, 0);
    strobe(0, 1, 1);
    step(mk(0, 0, 0, 1, 5, 0, 0, 1));
    strobe(0, 1, 0);
    step(mk(0, 1, 0, 1, 4, 1, 0, 1));
    strobe(0, 1, 0);
    step(mk(1, 2, 0, 1, 3, 2, 0, 1));
    drain();

    // reset while a pixel is in flight: nothing emerges
    strobe(0, 0, 1);
    reset = 1;
    tick();
    reset = 0;
    drain();

`ifdef BG_AFFINE_MOSAIC_EN
    cfg(0, 0, 0, 16'h100, 0, 0, 16'h100, 255, 255, 0, 0);
    cfg(1, 0, 0, 16'h100, 0, 0, 16'h100, 255, 255, 0, 0);
    mosaic_en = 2'b01;
    mosaic_h  = 4'd2;
    strobe(1, 1, 0);
    for (int k = 0; k < 6; k++)
      step(mk((k / 3) * 3, 0, 0, 1, k, 0, 0, 1));
    drain();
    mosaic_en = '0;
`endif

    repeat (4) tick();
    while (sb.size() != 0) begin
      void'(sb.pop_front());
      checks++;
      errors++;
      $error("FAIL drain: got none expected pending result");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bg_affine_overflow_unit.md
# bg_affine_overflow_unit

Multi-channel affine background coordinate generator with per-channel overflow handling for the GBA background processing circuit. Each cycle's `pixel_step` produces one texture coordinate per affine background (BG2/BG3), and `line_start` steps the per-line reference point. Each output coordinate is then range-checked against the background size and either wrapped or flagged transparent. Outputs feed the tile/bitmap fetch stage.

## Interface
Parameters:
- `CHANNELS`, 2: number of affine backgrounds handled in parallel.
- `COORD_W`, 28: signed fixed-point reference coordinate width (20.8).
- `PARAM_W`, 16: signed affine parameter width (8.8).
- `SIZE_W`, 10: texture coordinate width.

Ports (per-channel buses are packed, channel 0 in the LSBs):
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  reload line reference from `ref_x`/`ref_y`.
- `line_start`  in  1  begin scanline.
- `pixel_step`  in  1  emit one pixel, advance the accumulators.
- `ref_x`, `ref_y`  in  CHANNELS*COORD_W  BGxX/BGxY reference points.
- `pa`, `pb`, `pc`, `pd`  in  CHANNELS*PARAM_W  affine parameters.
- `hmax`, `vmax`  in  CHANNELS*SIZE_W  background size minus 1 (2^n−1).
- `bitmapped`  in  CHANNELS  channel is in bitmap mode.
- `wrap`  in  CHANNELS  wrap-around overflow enable.
- `tex_x`, `tex_y`  out  CHANNELS*SIZE_W  texture coordinate.
- `transparent`  out  CHANNELS  pixel forced transparent.
- `out_valid`  out  1  outputs valid this cycle.

## Operation
Per-channel registers: `lx`, `ly` (line reference) and `cx`, `cy` (current pixel). All are signed and COORD_W wide.
- Priority is `frame_start` > `line_start` > `pixel_step`.
- `frame_start`: `lx<=ref_x`, `ly<=ref_y`.
- `line_start`: `cx<=lx`, `cy<=ly`, then `lx<=lx+pb`, `ly<=ly+pd`, where pb/pd are sign-extended. If `frame_start` is high in the same cycle, the newly loaded `ref_x`/`ref_y` are used instead of `lx`/`ly`.
- `pixel_step` (neither other strobe high): capture `cx`, `cy` into stage 1, then `cx+=pa`, `cy+=pc`. If a higher-priority strobe is high, `pixel_step` is ignored and no output is produced.
- Accumulator arithmetic is modulo 2^COORD_W; no saturation.

Stage 2 (overflow), per channel, with `ix = cx>>>8` and `iy = cy>>>8` (arithmetic shift):
- `ovf` = (`ix`<0) | (`ix`>`hmax`) | (`iy`<0) | (`iy`>`vmax`), evaluated as signed compares.
- If `ovf` is false: `tex_x=ix[SIZE_W-1:0]`, `tex_y=iy[SIZE_W-1:0]`, `transparent=0`.
- If `ovf` is true and `bitmapped`: `transparent=1`. `tex_x`/`tex_y` hold the masked values below but are don't-care.
- If `ovf` is true, not `bitmapped`, and `wrap`: `tex_x=ix&hmax`, `tex_y=iy&vmax`, `transparent=0`.
- If `ovf` is true, not `bitmapped`, and not `wrap`: `transparent=1`.
- `hmax`, `vmax`, `bitmapped` and `wrap` are sampled in stage 1 together with the coordinate.

## Timing
- Latency: `pixel_step` at cycle N gives `out_valid` and the matching outputs at N+2. Back-to-back steps give one result per cycle, with no stall or backpressure.
- `out_valid` is 0 in every cycle not 2 cycles after an accepted step.
- Outputs hold their last value when `out_valid`=0.
- Reset values: `lx`, `ly`, `cx`, `cy`, pipeline registers, `tex_x`, `tex_y` = 0; `transparent` = 0; `out_valid` = 0.
- A `reset` asserted mid-line clears both pipeline stages immediately; no queued pixel emerges.
- A `line_start` arriving while pixels are in flight does not corrupt them. In-flight results complete with their captured values.

## Configuration
- `BG_AFFINE_MOSAIC_EN` defined: adds inputs `mosaic_en` (CHANNELS) and `mosaic_h` (4).
  - A per-channel counter counts accepted steps modulo `mosaic_h+1` and clears on `line_start` and `reset`.
  - When `mosaic_en` is set and the counter is nonzero, stage 1 recaptures the previous captured coordinate instead of `cx`/`cy`. The accumulators still advance.
- `BG_AFFINE_MOSAIC_EN` undefined: the ports and counters are absent, and every step samples `cx`/`cy`.

## Test plan
- Identity transform: ref=0, pa=0x100, pc=0, pd=0x100, hmax=vmax=255. Frame start, line start, then 4 steps → tex_x 0,1,2,3, tex_y 0, transparent 0, each at step+2.
- Wrap: ref_x=254<<8, pa=0x100, wrap=1, hmax=255 → tex_x 254,255,0,1, transparent 0.
- Transparent: same stimulus with wrap=0 → transparent 0,0,1,1. With bitmapped=1 and wrap=1 → also 0,0,1,1.
- Negative coordinate: ref_x=−1<<8, wrap=1, hmax=127 → tex_x=127. With wrap=0 → transparent=1.
- Line stepping: pb=0x80, pd=0x100. Three line_starts, one step each → (x,y) = (0,0), (0,1), (1,2).
- Control behaviour: reset between a step and its output → `out_valid` stays 0. With `BG_AFFINE_MOSAIC_EN` defined, `mosaic_h=2` and pa=0x100 → tex_x 0,0,0,3,3,3.
